// File: rtl/sparc_exu_ecl_divseq_pkg.sv
// rtl/sparc_exu_ecl_divseq_pkg.sv - shared state encoding and defaults for the divide sequencer
package sparc_exu_ecl_divseq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    localparam int DIV_ITER_DEF = 64;

endpackage

// File: rtl/sparc_exu_ecl_cnt6.sv
// rtl/sparc_exu_ecl_cnt6.sv - 6-bit iteration counter with synchronous clear and shadow load
module sparc_exu_ecl_cnt6 (
    input  logic       clk,
    input  logic       se,
    input  logic       reset,
    input  logic       shadow_ld,
    input  logic [5:0] shadow_din,
    output logic [5:0] cnt
);

    // No async reset on these flops: the owner holds reset high whenever the count is meaningless.
    // Scan shifting freezes the functional increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 6'd0;
        end else if (shadow_ld) begin
            cnt <= shadow_din;
        end else if (!se) begin
            cnt <= cnt + 6'd1;
        end
    end

endmodule

// File: rtl/sparc_exu_ecl_divseq.sv
// rtl/sparc_exu_ecl_divseq.sv - init/iterate/fix/done sequencer for the EXU integer divider
module sparc_exu_ecl_divseq
    import sparc_exu_ecl_divseq_pkg::*;
#(
    parameter int ITER  = DIV_ITER_DEF,
    parameter int TID_W = 2
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             se,
    input  logic             div_req,
    input  logic [TID_W-1:0] div_tid,
    input  logic             div_signed,
    input  logic             div_kill,
    input  logic [TID_W-1:0] kill_tid,
    input  logic             wb_ack,
    output logic             div_ack,
    output logic             div_busy,
    output logic             dp_init,
    output logic             dp_iter,
    output logic             dp_fix,
    output logic             iter_last,
    output logic [5:0]       cnt,
    output logic             div_done,
    output logic [TID_W-1:0] done_tid
);

    localparam logic [5:0] LAST_IDX = 6'(ITER - 1);

    div_state_e       state;
    div_state_e       nxt;
    logic [TID_W-1:0] cur_tid;
    logic             sgn;
    logic [5:0]       cnt_raw;
    logic             cnt_clr;
    logic             kill_hit;

    // Held in clear outside RUN, so entry to RUN always starts at index 0 and the
    // wrap after the final iteration is never visible.
    assign cnt_clr = (state != RUN) | ~arst_l;

    sparc_exu_ecl_cnt6 u_cnt (
        .clk        (clk),
        .se         (se),
        .reset      (cnt_clr),
        .shadow_ld  (1'b0),
        .shadow_din (6'd0),
        .cnt        (cnt_raw)
    );

    assign kill_hit  = div_kill & (kill_tid == cur_tid);
    assign div_ack   = arst_l & (state == IDLE) & div_req & ~(div_kill & (kill_tid == div_tid));
    assign cnt       = (state == RUN) ? cnt_raw : 6'd0;
    assign iter_last = (state == RUN) & (cnt_raw == LAST_IDX);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (div_ack) nxt = INIT;
            INIT: nxt = kill_hit ? IDLE : RUN;
            RUN: begin
                if (kill_hit) begin
                    nxt = IDLE;
                end else if (cnt_raw == LAST_IDX) begin
                    nxt = sgn ? FIX : DONE;
                end
            end
            FIX:  nxt = kill_hit ? IDLE : DONE;
            // wb_ack and a kill both lead to IDLE; the result counts as consumed either way.
            DONE: if (wb_ack | kill_hit) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= IDLE;
            cur_tid  <= '0;
            sgn      <= 1'b0;
            div_busy <= 1'b0;
            dp_init  <= 1'b0;
            dp_iter  <= 1'b0;
            dp_fix   <= 1'b0;
            div_done <= 1'b0;
            done_tid <= '0;
        end else begin
            state <= nxt;
            if (div_ack) begin
                cur_tid <= div_tid;
                sgn     <= div_signed;
            end
            div_busy <= (nxt != IDLE);
            dp_init  <= (nxt == INIT);
            dp_iter  <= (nxt == RUN);
            dp_fix   <= (nxt == FIX);
            div_done <= (nxt == DONE);
            done_tid <= (nxt == DONE) ? cur_tid : '0;
        end
    end

endmodule

// File: tb/tb_sparc_exu_ecl_divseq.sv
// tb/tb_sparc_exu_ecl_divseq.sv - directed bench for the divide sequencer, ITER=64 and ITER=2 side by side
module tb_sparc_exu_ecl_divseq;

    logic       clk;
    logic       arst_l;
    logic       se;
    logic       div_req;
    logic [1:0] div_tid;
    logic       div_signed;
    logic       div_kill;
    logic [1:0] kill_tid;
    logic       wb_ack;

    logic       o_ack  [2];
    logic       o_busy [2];
    logic       o_init [2];
    logic       o_iter [2];
    logic       o_fix  [2];
    logic       o_last [2];
    logic       o_done [2];
    logic [5:0] o_cnt  [2];
    logic [1:0] o_tid  [2];

    int n_vec  = 0;
    int n_miss = 0;

    int   m_it   [2] = '{64, 2};
    bit   m_busy [2] = '{0, 0};
    int   m_age  [2] = '{0, 0};
    bit   m_sgn  [2] = '{0, 0};
    logic [1:0] m_tid [2] = '{2'd0, 2'd0};

    sparc_exu_ecl_divseq #(.ITER(64), .TID_W(2)) u64 (
        .clk(clk), .arst_l(arst_l), .se(se), .div_req(div_req), .div_tid(div_tid),
        .div_signed(div_signed), .div_kill(div_kill), .kill_tid(kill_tid), .wb_ack(wb_ack),
        .div_ack(o_ack[0]), .div_busy(o_busy[0]), .dp_init(o_init[0]), .dp_iter(o_iter[0]),
        .dp_fix(o_fix[0]), .iter_last(o_last[0]), .cnt(o_cnt[0]), .div_done(o_done[0]),
        .done_tid(o_tid[0])
    );

    sparc_exu_ecl_divseq #(.ITER(2), .TID_W(2)) u2 (
        .clk(clk), .arst_l(arst_l), .se(se), .div_req(div_req), .div_tid(div_tid),
        .div_signed(div_signed), .div_kill(div_kill), .kill_tid(kill_tid), .wb_ack(wb_ack),
        .div_ack(o_ack[1]), .div_busy(o_busy[1]), .dp_init(o_init[1]), .dp_iter(o_iter[1]),
        .dp_fix(o_fix[1]), .iter_last(o_last[1]), .cnt(o_cnt[1]), .div_done(o_done[1]),
        .done_tid(o_tid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: each instance is either idle or busy with an age counted in cycles since its ack.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!arst_l) begin
                m_busy[i] = 0;
            end else if (!m_busy[i]) begin
                if (div_req && !(div_kill && kill_tid == div_tid)) begin
                    m_busy[i] = 1;
                    m_age[i]  = 1;
                    m_sgn[i]  = div_signed;
                    m_tid[i]  = div_tid;
                end
            end else begin
                if (m_age[i] >= m_it[i] + 2 + int'(m_sgn[i])) begin
                    if (wb_ack || (div_kill && kill_tid == m_tid[i])) m_busy[i] = 0;
                end else if (div_kill && kill_tid == m_tid[i]) begin
                    m_busy[i] = 0;
                end else begin
                    m_age[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit act;
            int a;
            int it;
            bit e_iter;
            bit e_done;
            string p;
            p      = $sformatf("u%0d", m_it[i]);
            act    = arst_l && m_busy[i];
            a      = m_age[i];
            it     = m_it[i];
            e_iter = act && a >= 2 && a <= it + 1;
            e_done = act && a >= it + 2 + int'(m_sgn[i]);
            chk({p, " div_ack"}, int'(o_ack[i]),
                int'(arst_l && !m_busy[i] && div_req && !(div_kill && kill_tid == div_tid)));
            chk({p, " div_busy"},  int'(o_busy[i]), int'(act));
            chk({p, " dp_init"},   int'(o_init[i]), int'(act && a == 1));
            chk({p, " dp_iter"},   int'(o_iter[i]), int'(e_iter));
            chk({p, " iter_last"}, int'(o_last[i]), int'(e_iter && a == it + 1));
            chk({p, " cnt"},       int'(o_cnt[i]),  e_iter ? a - 2 : 0);
            chk({p, " dp_fix"},    int'(o_fix[i]),  int'(act && m_sgn[i] && a == it + 2));
            chk({p, " div_done"},  int'(o_done[i]), int'(e_done));
            if (e_done) chk({p, " done_tid"}, int'(o_tid[i]), int'(m_tid[i]));
        end
    end

    initial begin
        arst_l = 1'b0; se = 1'b0; div_req = 1'b0; div_tid = 2'd0; div_signed = 1'b0;
        div_kill = 1'b0; kill_tid = 2'd0; wb_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset div_busy", int'(o_busy[0]), 0);
        chk("reset cnt", int'(o_cnt[0]), 0);
        tick();
        arst_l = 1'b1;
        tick();

        // Request with a same-cycle matching kill is refused
        div_req = 1'b1; div_tid = 2'd1; div_kill = 1'b1; kill_tid = 2'd1;
        @(negedge clk);
        chk("same-cycle kill ack", int'(o_ack[0]), 0);
        tick();
        div_req = 1'b0; div_kill = 1'b0; kill_tid = 2'd0;
        @(negedge clk);
        chk("same-cycle kill busy", int'(o_busy[0]), 0);
        tick();

        // Unsigned, wb_ack in cycle 70
        div_tid = 2'd0; div_signed = 1'b0;
        for (int c = 0; c <= 71; c++) begin
            div_req = (c == 0);
            wb_ack  = (c == 70);
            @(negedge clk);
            case (c)
                0:  begin chk("u ack64", int'(o_ack[0]), 1); chk("u ack2", int'(o_ack[1]), 1); end
                1:  chk("u init64 c1", int'(o_init[0]), 1);
                2:  chk("u cnt2 c2", int'(o_cnt[1]), 0);
                3:  begin chk("u last2 c3", int'(o_last[1]), 1); chk("u cnt2 c3", int'(o_cnt[1]), 1);
                          chk("u done2 c3", int'(o_done[1]), 0); end
                4:  chk("u done2 c4", int'(o_done[1]), 1);
                65: begin chk("u last64 c65", int'(o_last[0]), 1); chk("u cnt64 c65", int'(o_cnt[0]), 63);
                          chk("u done64 c65", int'(o_done[0]), 0); end
                66: begin chk("u done64 c66", int'(o_done[0]), 1); chk("u cnt64 c66", int'(o_cnt[0]), 0); end
                70: chk("u done64 c70", int'(o_done[0]), 1);
                71: chk("u busy64 c71", int'(o_busy[0]), 0);
                default: ;
            endcase
            tick();
        end

        // Signed, tid 2, wb_ack in cycle 68
        div_tid = 2'd2; div_signed = 1'b1;
        for (int c = 0; c <= 69; c++) begin
            div_req = (c == 0);
            wb_ack  = (c == 68);
            @(negedge clk);
            case (c)
                4:  chk("s fix2 c4", int'(o_fix[1]), 1);
                5:  begin chk("s done2 c5", int'(o_done[1]), 1); chk("s tid2 c5", int'(o_tid[1]), 2); end
                65: chk("s fix64 c65", int'(o_fix[0]), 0);
                66: begin chk("s fix64 c66", int'(o_fix[0]), 1); chk("s done64 c66", int'(o_done[0]), 0); end
                67: begin chk("s fix64 c67", int'(o_fix[0]), 0); chk("s done64 c67", int'(o_done[0]), 1);
                          chk("s tid64 c67", int'(o_tid[0]), 2); end
                69: chk("s busy64 c69", int'(o_busy[0]), 0);
                default: ;
            endcase
            tick();
        end

        // Kill: foreign tid at cnt 9, owning tid at cnt 10
        div_tid = 2'd1; div_signed = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            div_req  = (c == 0);
            div_kill = (c == 11 || c == 12);
            kill_tid = (c == 11) ? 2'd3 : 2'd1;
            @(negedge clk);
            case (c)
                12: begin chk("k busy64 c12", int'(o_busy[0]), 1); chk("k cnt64 c12", int'(o_cnt[0]), 10);
                          chk("k done2 c12", int'(o_done[1]), 1); end
                13: begin chk("k busy64 c13", int'(o_busy[0]), 0); chk("k iter64 c13", int'(o_iter[0]), 0);
                          chk("k done2 c13", int'(o_done[1]), 0); end
                66: chk("k done64 c66", int'(o_done[0]), 0);
                default: ;
            endcase
            tick();
        end
        div_kill = 1'b0; kill_tid = 2'd0;

        // Asynchronous reset in the middle of RUN
        div_tid = 2'd0;
        for (int c = 0; c < 22; c++) begin
            div_req = (c == 0);
            tick();
        end
        chk("r cnt64 before", int'(o_cnt[0]), 20);
        arst_l = 1'b0;
        #1;
        chk("r busy64 async", int'(o_busy[0]), 0);
        chk("r cnt64 async", int'(o_cnt[0]), 0);
        chk("r busy2 async", int'(o_busy[1]), 0);
        tick();
        arst_l = 1'b1;

        // Fresh request after reset; DONE with wb_ack plus matching kill and a back-to-back request
        for (int c = 0; c <= 70; c++) begin
            div_req  = (c == 0 || c == 67 || c == 68);
            wb_ack   = (c == 67);
            div_kill = (c == 67);
            @(negedge clk);
            case (c)
                0:  chk("b ack64 c0", int'(o_ack[0]), 1);
                1:  chk("b init64 c1", int'(o_init[0]), 1);
                66: chk("b done64 c66", int'(o_done[0]), 1);
                67: begin chk("b ack64 c67", int'(o_ack[0]), 0); chk("b done64 c67", int'(o_done[0]), 1); end
                68: begin chk("b ack64 c68", int'(o_ack[0]), 1); chk("b busy64 c68", int'(o_busy[0]), 0); end
                69: chk("b init64 c69", int'(o_init[0]), 1);
                default: ;
            endcase
            tick();
        end
        div_req = 1'b0; wb_ack = 1'b0; div_kill = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
